// File: rtl/rptr_wdomain_receiver.sv
// Write-side receiver for the async FIFO read pointer: 2-flop Gray synchronizer, Gray->binary, occupancy/free/almost_full.
// Optional Gray-sequence checker enabled by defining RPTR_GRAY_CHECK_EN.
module rptr_wdomain_receiver #(
   parameter int PTR_WIDTH = 8,
   parameter int AF_THRESH = (1 << PTR_WIDTH) - 4
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic [PTR_WIDTH:0]   g_rptr,
   input  logic [PTR_WIDTH:0]   b_wptr,
   input  logic                 err_clr,
   output logic [PTR_WIDTH:0]   g_rptr_sync,
   output logic [PTR_WIDTH:0]   b_rptr_sync,
   output logic [PTR_WIDTH:0]   wr_count,
   output logic [PTR_WIDTH:0]   wr_free,
   output logic                 almost_full,
   output logic                 ptr_err
);

   localparam int PW = PTR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {PTR_WIDTH{1'b0}}};
   localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] sync1;
   logic [PW-1:0] diff;
   logic [PW-1:0] count_nxt;
   logic          overflow;
   logic          gray_err;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         sync1       <= '0;
         g_rptr_sync <= '0;
         b_rptr_sync <= '0;
      end else begin
         sync1       <= g_rptr;
         g_rptr_sync <= sync1;
         b_rptr_sync <= gray2bin(g_rptr_sync);
      end
   end

   // An illegal difference (> DEPTH) is clamped so downstream never sees more than a full FIFO.
   always_comb begin
      diff      = b_wptr - b_rptr_sync;
      overflow  = (diff > DEPTH);
      count_nxt = overflow ? DEPTH : diff;
   end

`ifdef RPTR_GRAY_CHECK_EN
   logic [PW-1:0] g_prev;
   logic          chk_armed;
   logic          multi_bit;
   logic          back_step;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         g_prev    <= '0;
         chk_armed <= 1'b0;
      end else begin
         g_prev    <= g_rptr_sync;
         chk_armed <= 1'b1;
      end
   end

   always_comb begin
      multi_bit = ($countones(g_rptr_sync ^ g_prev) > 1);
      back_step = (gray2bin(g_rptr_sync) == (gray2bin(g_prev) - PW'(1)));
      gray_err  = chk_armed & (multi_bit | back_step);
   end
`else
   assign gray_err = 1'b0;
`endif

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wr_count    <= '0;
         wr_free     <= DEPTH;
         almost_full <= 1'b0;
         ptr_err     <= 1'b0;
      end else begin
         wr_count    <= count_nxt;
         wr_free     <= DEPTH - count_nxt;
         almost_full <= (diff >= AF_LVL);
         // A fresh error takes priority over a simultaneous clear.
         if (overflow || gray_err) begin
            ptr_err <= 1'b1;
         end else if (err_clr) begin
            ptr_err <= 1'b0;
         end
      end
   end

endmodule
